uart_tx_fifo: RTL and testbench

Second-generation APB UART transmitter with a parametrised data width (5..DATA_W data bits) and an internal TX FIFO, so software can queue a burst of characters. It adds hardware CTS flow control, break generation, a frame-done pulse and a FIFO level output for interrupt logic. It sits between the APB register block and the tx pad, and shares cfg_* semantics with the existing UART.

---
 rtl/uart_tx_fifo.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO, CTS gating, break generation and frame-done pulse.
// Frames: start, 5..DATA_W data bits LSB first, optional parity, one or two stop bits.
module uart_tx_fifo #(
  parameter  int DATA_W     = 9,
  parameter  int FIFO_DEPTH = 8,
  parameter  int DIV_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cfg_en_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [3:0]        cfg_bits_i,
  input  logic              cfg_parity_en_i,
  input  logic [1:0]        cfg_parity_sel_i,
  input  logic              cfg_stop_bits_i,
  input  logic              cfg_cts_en_i,
  input  logic              cts_ni,
  input  logic              break_req_i,
  input  logic              fifo_clr_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              tx_empty_o,
  output logic [LVL_W-1:0]  fifo_level_o,
  output logic              frame_done_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  lvl_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [3:0]        idx_q, idx_d, nbits;
  logic              par_q, par_d, brk_q, brk_d, tx_q, tx_d, done_q;
  logic              cts_meta_q, cts_q;
  logic              full, empty, push, pop, done, fin, bit_end, can_start, par_bit;

  assign full         = (lvl_q == LVL_W'(FIFO_DEPTH));
  assign empty        = (lvl_q == '0);
  // rstn_i gating keeps ready low while reset is held.
  assign tx_ready_o   = rstn_i & cfg_en_i & ~full & ~fifo_clr_i;
  assign push         = tx_valid_i & tx_ready_o;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE);
  assign tx_empty_o   = empty & (state_q == IDLE);
  assign fifo_level_o = lvl_q;
  assign frame_done_o = done_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else if (fifo_clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      lvl_q <= lvl_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cts_meta_q <= 1'b1;
      cts_q      <= 1'b1;
    end else begin
      cts_meta_q <= cts_ni;
      cts_q      <= cts_meta_q;
    end
  end

  always_comb begin
    nbits = cfg_bits_i;
    if (cfg_bits_i < 4'd5)               nbits = 4'd5;
    else if (cfg_bits_i > 4'(DATA_W))    nbits = 4'(DATA_W);
  end

  // >= rather than == so a mid-frame divider change cannot strand the counter.
  assign bit_end   = (cnt_q >= cfg_div_i);
  assign can_start = ~empty & (~cfg_cts_en_i | ~cts_q);

  always_comb begin
    unique case (cfg_parity_sel_i)
      2'b00:   par_bit = par_q;
      2'b01:   par_bit = ~par_q;
      2'b10:   par_bit = 1'b0;
      default: par_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fin     = 1'b0;
    done    = 1'b0;
    sh_d    = sh_q;
    idx_d   = idx_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (break_req_i) state_d = BREAK;
        else if (can_start) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          par_d = par_q ^ sh_q[0];
          idx_d = idx_q + 4'd1;
          if (idx_q >= nbits - 4'd1) state_d = cfg_parity_en_i ? PARITY : STOP1;
        end
      end
      PARITY: if (bit_end) state_d = STOP1;
      STOP1: begin
        if (bit_end) begin
          if (brk_q || !cfg_stop_bits_i) fin = 1'b1;
          else                           state_d = STOP2;
        end
      end
      STOP2:  if (bit_end) fin = 1'b1;
      BREAK:  if (!break_req_i) state_d = STOP1;
      default: state_d = IDLE;
    endcase
    // Leaving the last stop bit chains straight into the next frame when possible.
    if (fin) begin
      done = ~brk_q;
      if (break_req_i) state_d = BREAK;
      else if (can_start) begin
        pop     = 1'b1;
        state_d = START;
      end else state_d = IDLE;
    end
    if (!cfg_en_i) begin
      state_d = IDLE;
      pop     = 1'b0;
      done    = 1'b0;
    end
    if (pop) begin
      sh_d  = mem_q[rd_ptr_q];
      idx_d = '0;
      par_d = 1'b0;
    end
  end

  always_comb begin
    brk_d = brk_q;
    if (state_d == BREAK)                          brk_d = 1'b1;
    else if (state_d == IDLE || state_d == START)  brk_d = 1'b0;
    cnt_d = (state_q == IDLE || state_q == BREAK || bit_end || !cfg_en_i) ? '0 : cnt_q + DIV_W'(1);
    unique case (state_q)
      START, BREAK: tx_d = 1'b0;
      DATA:         tx_d = sh_q[0];
      PARITY:       tx_d = par_bit;
      default:      tx_d = 1'b1;
    endcase
    if (!cfg_en_i) tx_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
      tx_q    <= tx_d;
      done_q  <= done;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frames, parity, CTS back-pressure, break, flush, reset.
module tb_uart_tx_fifo;
  logic        clk, rstn;
  logic        cfg_en, cfg_parity_en, cfg_stop_bits, cfg_cts_en;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_bits;
  logic [1:0]  cfg_parity_sel;
  logic        cts_n, break_req, fifo_clr, tx_valid;
  logic [8:0]  tx_data;
  logic        tx_ready, tx, busy, tx_empty, frame_done;
  logic [3:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  uart_tx_fifo #(.DATA_W(9), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
    .cfg_bits_i(cfg_bits), .cfg_parity_en_i(cfg_parity_en),
    .cfg_parity_sel_i(cfg_parity_sel), .cfg_stop_bits_i(cfg_stop_bits),
    .cfg_cts_en_i(cfg_cts_en), .cts_ni(cts_n), .break_req_i(break_req),
    .fifo_clr_i(fifo_clr), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .tx_o(tx), .busy_o(busy), .tx_empty_o(tx_empty),
    .fifo_level_o(fifo_level), .frame_done_o(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [8:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits for the start bit, then records one sample per bit and checks each bit
  // holds for div+1 cycles. Returns on the first cycle after the frame.
  task automatic rx_frame(input int nb, input int div, output logic [15:0] bits, output int gap);
    int unstable;
    gap = 0;
    unstable = 0;
    bits = '0;
    while (tx !== 1'b0 && gap < 300) begin
      @(negedge clk);
      gap++;
    end
    for (int c = 0; c < nb * (div + 1); c++) begin
      if (c > 0) @(negedge clk);
      if (c % (div + 1) == 0) bits[c / (div + 1)] = tx;
      else if (tx !== bits[c / (div + 1)]) unstable++;
    end
    chk("bit_stable", 32'(unstable), 32'd0);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int div, input int nb, input logic pe, input logic [1:0] ps,
                         input logic sb);
    cfg_div        = 16'(div);
    cfg_bits       = 4'(nb);
    cfg_parity_en  = pe;
    cfg_parity_sel = ps;
    cfg_stop_bits  = sb;
  endtask

  initial begin
    logic [15:0] bits;
    int gap, fd0, lows, n;

    rstn = 1'b0; cfg_en = 1'b1; cfg_cts_en = 1'b0; cts_n = 1'b1;
    break_req = 1'b0; fifo_clr = 1'b0; tx_valid = 1'b0; tx_data = '0;
    set_cfg(3, 8, 1'b0, 2'b00, 1'b0);
    #23;
    chk("rst_tx",    32'(tx), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_empty", 32'(tx_empty), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(tx_ready), 32'd1);

    // 8N1, div=3, 0xA5
    fd0 = fd_cnt;
    wr(9'h0A5);
    rx_frame(10, 3, bits, gap);
    chk("a5_frame", 32'(bits), 32'h34A);
    repeat (3) @(negedge clk);
    chk("a5_done_cnt", 32'(fd_cnt - fd0), 32'd1);
    chk("a5_empty", 32'(tx_empty), 32'd1);

    // 9 bits, even parity, 2 stop, 0x1FF -> 13-bit frame
    set_cfg(1, 9, 1'b1, 2'b00, 1'b1);
    fd0 = fd_cnt;
    wr(9'h1FF);
    rx_frame(13, 1, bits, gap);
    chk("9e2_frame", 32'(bits), 32'h1FFE);
    chk("9e2_idle_after", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    chk("9e2_done_cnt", 32'(fd_cnt - fd0), 32'd1);

    // 5 bits, odd parity, 1 stop, 0xFF -> 5 ones, parity 0
    set_cfg(2, 5, 1'b1, 2'b01, 1'b0);
    wr(9'h0FF);
    rx_frame(8, 2, bits, gap);
    chk("5o1_frame", 32'(bits), 32'hBE);
    repeat (2) @(negedge clk);

    // Fill FIFO with CTS deasserted
    set_cfg(1, 8, 1'b0, 2'b00, 1'b0);
    cfg_cts_en = 1'b1;
    cts_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("fill_ready%0d", i), 32'(tx_ready), (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("fill_level%0d", i), 32'(fifo_level), 32'(i < 8 ? i : 8));
      tx_data = 9'(9'h010 + 9'(i));
      tx_valid = 1'b1;
    end
    @(negedge clk); tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("fill_level_full", 32'(fifo_level), 32'd8);
    chk("fill_tx_idle", 32'(tx), 32'd1);
    chk("fill_busy", 32'(busy), 32'd0);

    // Release CTS: back-to-back frames
    cts_n = 1'b0;
    rx_frame(10, 1, bits, gap);
    chk("b2b_f0", 32'(bits), 32'h220);
    chk("b2b_lvl0", 32'(fifo_level), 32'd6);
    rx_frame(10, 1, bits, gap);
    chk("b2b_f1", 32'(bits), 32'h222);
    chk("b2b_gap1", 32'(gap), 32'd0);
    chk("b2b_lvl1", 32'(fifo_level), 32'd5);

    // Deassert CTS mid-frame: frame 2 completes, frame 3 held
    cts_n = 1'b1;
    rx_frame(10, 1, bits, gap);
    chk("cts_f2", 32'(bits), 32'h224);
    chk("cts_gap2", 32'(gap), 32'd0);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    chk("cts_hold_lows", 32'(lows), 32'd0);
    chk("cts_hold_lvl", 32'(fifo_level), 32'd5);

    // Flush mid-frame
    cts_n = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("clr_started", 32'(busy), 32'd1);
    chk("clr_lvl_before", 32'(fifo_level), 32'd4);
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    rx_frame(10, 1, bits, gap);
    chk("clr_frame", 32'(bits), 32'h226);
    chk("clr_lvl_after", 32'(fifo_level), 32'd0);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    chk("clr_no_more", 32'(lows), 32'd0);
    chk("clr_empty", 32'(tx_empty), 32'd1);

    // Break for 50 cycles while idle
    cfg_cts_en = 1'b0;
    fd0 = fd_cnt;
    lows = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
      if (c == 0)  break_req = 1'b1;
      if (c == 50) break_req = 1'b0;
    end
    chk("brk_lows", 32'(lows), 32'd50);
    chk("brk_busy", 32'(busy), 32'd0);
    chk("brk_tx", 32'(tx), 32'd1);
    chk("brk_no_done", 32'(fd_cnt - fd0), 32'd0);

    // Disabled: no writes accepted
    @(negedge clk); cfg_en = 1'b0;
    #1 chk("dis_ready", 32'(tx_ready), 32'd0);
    @(negedge clk); cfg_en = 1'b1;

    // Async reset mid-DATA with a low data bit on the line
    set_cfg(3, 8, 1'b0, 2'b00, 1'b0);
    wr(9'h000);
    wr(9'h000);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("mid_data_busy", 32'(busy), 32'd1);
    chk("mid_data_tx", 32'(tx), 32'd0);
    rstn = 1'b0;
    #1;
    chk("arst_tx", 32'(tx), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_empty", 32'(tx_empty), 32'd1);
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
